basic_array2d_store: RTL and testbench
======================================

Name: basic_array2d_store

Overview:
- Storage stage for a two-dimensional BASIC array, e.g. DIM A(4,12).
- Consumes indexed read and write commands from the generated control/dataflow logic, in place of a raw reg array with unchecked indexing.
- Zeroes the array on reset and on each DIM execution.
- Computes row-major addresses, bounds-checks subscripts, and returns read data or a SUBSCRIPT OUT OF RANGE error through a fixed-latency pipeline.

Parameters:
DATA_W, 32, data width, signed
IDX_W, 32, width of subscript inputs, signed
MAX_I, 4, highest legal first subscript; legal range is 0..MAX_I
MAX_J, 12, highest legal second subscript; legal range is 0..MAX_J
DEPTH, (MAX_I+1)*(MAX_J+1), number of storage words (derived, 65 at defaults)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
dim_start  in  1  one-cycle pulse: DIM executed, re-zero the array
busy  out  1  high while clearing
cmd_valid  in  1  command present
cmd_ready  out  1  combinational: (state==IDLE) && !dim_start
cmd_write  in  1  1 = write, 0 = read
cmd_i  in  IDX_W  first subscript, signed
cmd_j  in  IDX_W  second subscript, signed
cmd_wdata  in  DATA_W  write data
rd_valid  out  1  one-cycle pulse: rd_data valid
rd_data  out  DATA_W  read result; holds its last value between reads
wr_done  out  1  one-cycle pulse: write committed
err_valid  out  1  one-cycle pulse: subscript out of range
err_code  out  2  bit0 = I out of range, bit1 = J out of range; valid with err_valid
err_sticky  out  1  set by any error; cleared only by reset or dim_start

Behaviour:
- Reset values: busy=1, rd_valid=0, rd_data=0, wr_done=0, err_valid=0, err_code=0, err_sticky=0.
- Also on reset: pipeline valid bits=0, clear counter=0, state=CLEAR.
- FSM CLEAR:
  - Writes 0 to address clr_addr on each edge, then clr_addr++.
  - After the edge that writes DEPTH-1, state goes to IDLE.
  - busy is high for exactly DEPTH cycles after reset deasserts.
- FSM IDLE: cmd_ready=1 unless dim_start is high.
- dim_start in IDLE or CLEAR:
  - Next state is CLEAR with clr_addr=0; a restart occurs if already clearing.
  - err_sticky and both pipeline valid bits clear on the same edge, so in-flight commands produce no response.
- dim_start with cmd_valid in the same cycle: dim_start wins; the command is not accepted.
- Accept: cmd_valid && cmd_ready at edge N.
- Stage 1 (edge N) registers:
  - write, wdata;
  - inI = (cmd_i>=0 && cmd_i<=MAX_I), using a signed compare;
  - inJ = (cmd_j>=0 && cmd_j<=MAX_J), using a signed compare;
  - addr = cmd_i*(MAX_J+1) + cmd_j, truncated to clog2(DEPTH) bits and used only if in range.
- Stage 2 (edge N+1), in-range:
  - A write stores wdata to mem[addr] and pulses wr_done.
  - A read loads rd_data from mem[addr] and pulses rd_valid.
- Stage 2, out of range:
  - No memory access, no rd_valid, no wr_done.
  - err_valid pulses, err_code = {!inJ, !inI}, err_sticky is set.
- Response pulses are high in the cycle following edge N+1, i.e. 2 cycles after the accept cycle.
- The pipeline is fully pipelined: one command per cycle, strictly in order. Exactly one of rd_valid, wr_done, err_valid fires per accepted command.
- Read-after-write to the same address in the next cycle returns the new data; writes commit in order before later reads.
- Memory is single-port, one access per edge; the CLEAR state never overlaps stage-2 traffic.
- Reset mid-operation (during CLEAR or with commands in flight):
  - All outputs take their reset values immediately.
  - Clearing restarts at 0 after release.

Test Plan:
1. Release reset, hold cmd_valid=1 → busy high exactly 65 cycles, cmd_ready rises on cycle 65. Read (4,12) → rd_valid 2 cycles after accept, rd_data=0.
2. Write A(i,j)=i+j for all 65 pairs back-to-back, then read all back-to-back → 65 wr_done pulses, then rd_valid every cycle. (2,7) returns 9, (4,12) returns 16, no err_valid.
3. Write (1,3)=77, read (1,3) in the next cycle → rd_data=77 on the cycle after wr_done.
4. Read (5,0) → err_valid, err_code=1, err_sticky=1, no rd_valid. Write (-1,13) → err_code=3, no wr_done, memory unchanged (read (0,12) still returns its prior value).
5. Two reads in flight, then pulse dim_start → no rd_valid or err_valid, err_sticky=0, busy high 65 cycles. Then read (2,7) → 0.
6. Assert reset when clr_addr=30 → busy=1 and outputs at reset values asynchronously. After release: full 65-cycle clear, then normal operation.

Source files
------------

// File: rtl/basic_array2d_store.sv
// Zeroed, bounds-checked storage for a 2-D BASIC array (DIM A(MAX_I,MAX_J)).
// Row-major addressing, two-stage command pipeline, in-order fixed-latency responses.
module basic_array2d_store #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 32,
  parameter int MAX_I  = 4,
  parameter int MAX_J  = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dim_start,
  output logic                     busy,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic signed [IDX_W-1:0]  cmd_i,
  input  logic signed [IDX_W-1:0]  cmd_j,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     wr_done,
  output logic                     err_valid,
  output logic [1:0]               err_code,
  output logic                     err_sticky
);

  localparam int DEPTH = (MAX_I + 1) * (MAX_J + 1);
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t              state_q;
  logic [AW-1:0]       clr_addr_q;
  logic                s1_valid_q;
  logic                s1_write_q;
  logic                s1_in_i_q;
  logic                s1_in_j_q;
  logic [AW-1:0]       s1_addr_q;
  logic [DATA_W-1:0]   s1_wdata_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                wr_done_q;
  logic                err_valid_q;
  logic [1:0]          err_code_q;
  logic                err_sticky_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                in_i_d;
  logic                in_j_d;
  logic [AW-1:0]       addr_d;
  logic                mem_wr;

  assign cmd_ready = (state_q == S_IDLE) && !dim_start;
  assign accept    = cmd_valid && cmd_ready;

  // Sign bit test stands in for ">= 0" so the upper-bound compare stays signed.
  always_comb begin
    in_i_d = !cmd_i[IDX_W-1] && (cmd_i <= $signed(IDX_W'(MAX_I)));
    in_j_d = !cmd_j[IDX_W-1] && (cmd_j <= $signed(IDX_W'(MAX_J)));
    addr_d = AW'(cmd_i) * AW'(MAX_J + 1) + AW'(cmd_j);
  end

  assign mem_wr = (state_q == S_IDLE) && !dim_start && s1_valid_q &&
                  s1_write_q && s1_in_i_q && s1_in_j_q;

  // Single port: clearing and stage-2 traffic are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem[clr_addr_q] <= '0;
    end else if (mem_wr) begin
      mem[s1_addr_q] <= s1_wdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clr_addr_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_write_q   <= 1'b0;
      s1_in_i_q    <= 1'b0;
      s1_in_j_q    <= 1'b0;
      s1_addr_q    <= '0;
      s1_wdata_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      wr_done_q    <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      rd_valid_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      err_valid_q <= 1'b0;
      s1_valid_q  <= accept;
      if (accept) begin
        s1_write_q <= cmd_write;
        s1_wdata_q <= cmd_wdata;
        s1_in_i_q  <= in_i_d;
        s1_in_j_q  <= in_j_d;
        s1_addr_q  <= addr_d;
      end
      if (dim_start) begin
        state_q      <= S_CLEAR;
        clr_addr_q   <= '0;
        err_sticky_q <= 1'b0;
      end else begin
        if (state_q == S_CLEAR) begin
          if (clr_addr_q == AW'(DEPTH - 1)) begin
            state_q <= S_IDLE;
          end
          clr_addr_q <= clr_addr_q + AW'(1);
        end
        if (s1_valid_q) begin
          if (s1_in_i_q && s1_in_j_q) begin
            if (s1_write_q) begin
              wr_done_q <= 1'b1;
            end else begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= mem[s1_addr_q];
            end
          end else begin
            err_valid_q  <= 1'b1;
            err_code_q   <= {!s1_in_j_q, !s1_in_i_q};
            err_sticky_q <= 1'b1;
          end
        end
      end
    end
  end

  assign busy       = (state_q == S_CLEAR);
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign wr_done    = wr_done_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_basic_array2d_store.sv
// Bench for basic_array2d_store: directed scenarios plus random traffic,
// checked every cycle against an array/queue reference model.
module tb_basic_array2d_store;

  localparam int DW    = 32;
  localparam int IW    = 32;
  localparam int MI    = 4;
  localparam int MJ    = 12;
  localparam int DEPTH = (MI + 1) * (MJ + 1);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 dim_start = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_write = 1'b0;
  logic signed [IW-1:0] cmd_i = '0;
  logic signed [IW-1:0] cmd_j = '0;
  logic [DW-1:0]        cmd_wdata = '0;
  logic                 busy, cmd_ready, rd_valid, wr_done, err_valid, err_sticky;
  logic [DW-1:0]        rd_data;
  logic [1:0]           err_code;

  always #5 clk = ~clk;

  basic_array2d_store #(.DATA_W(DW), .IDX_W(IW), .MAX_I(MI), .MAX_J(MJ)) dut (
    .clk(clk), .reset(reset), .dim_start(dim_start), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_i(cmd_i), .cmd_j(cmd_j), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_done(wr_done),
    .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: array contents, clear countdown, sticky flag, expected responses.
  typedef struct {
    int            kind;  // 0 read, 1 write, 2 error
    logic [DW-1:0] data;
    logic [1:0]    code;
    int            due;
  } resp_t;

  logic [DW-1:0] ref_mem [0:MI][0:MJ];
  int            busy_left = DEPTH;
  logic          sticky_m = 1'b0;
  int            cyc = 0;
  resp_t         q[$];

  logic          acc, ini, inj;
  int            ii, jj;
  resp_t         r;
  logic [2:0]    exp_p;

  task automatic zero_ref();
    for (int a = 0; a <= MI; a++)
      for (int b = 0; b <= MJ; b++)
        ref_mem[a][b] = '0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      busy_left = DEPTH;
      sticky_m  = 1'b0;
      q.delete();
      zero_ref();
    end else begin
      acc = cmd_valid && (busy_left == 0) && !dim_start;
      if (dim_start) begin
        busy_left = DEPTH;
        sticky_m  = 1'b0;
        zero_ref();
        while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (acc) begin
        ii  = int'(cmd_i);
        jj  = int'(cmd_j);
        ini = (ii >= 0) && (ii <= MI);
        inj = (jj >= 0) && (jj <= MJ);
        r.due  = cyc + 1;
        r.data = '0;
        r.code = '0;
        if (ini && inj) begin
          if (cmd_write) begin
            ref_mem[ii][jj] = cmd_wdata;
            r.kind = 1;
          end else begin
            r.kind = 0;
            r.data = ref_mem[ii][jj];
          end
        end else begin
          r.kind = 2;
          r.code = {!inj, !ini};
        end
        q.push_back(r);
      end
      #1;
      check("busy", 64'(busy), 64'(busy_left > 0));
      check("cmd_ready", 64'(cmd_ready), 64'((busy_left == 0) && !dim_start));
      exp_p = 3'b000;
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        case (r.kind)
          0:       exp_p = 3'b100;
          1:       exp_p = 3'b010;
          default: exp_p = 3'b001;
        endcase
        if (r.kind == 2) sticky_m = 1'b1;
      end
      check("resp{rd,wr,err}", 64'({rd_valid, wr_done, err_valid}), 64'(exp_p));
      if (exp_p == 3'b100) check("rd_data", 64'(rd_data), 64'(r.data));
      if (exp_p == 3'b001) check("err_code", 64'(err_code), 64'(r.code));
      check("err_sticky", 64'(err_sticky), 64'(sticky_m));
    end
  end

  task automatic drive(input logic v, input logic w, input int i, input int j, input logic [DW-1:0] d);
    @(negedge clk);
    dim_start = 1'b0;
    cmd_valid = v;
    cmd_write = w;
    cmd_i     = i;
    cmd_j     = j;
    cmd_wdata = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 0, '0);
  endtask

  task automatic pulse_dim();
    @(negedge clk);
    dim_start = 1'b1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 200; k++) begin
      if (busy_left == 0) break;
      idle(1);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, 64'(busy), 64'(1));
    check({pfx, "_rd_valid"}, 64'(rd_valid), 64'(0));
    check({pfx, "_rd_data"}, 64'(rd_data), 64'(0));
    check({pfx, "_wr_done"}, 64'(wr_done), 64'(0));
    check({pfx, "_err_valid"}, 64'(err_valid), 64'(0));
    check({pfx, "_err_code"}, 64'(err_code), 64'(0));
    check({pfx, "_err_sticky"}, 64'(err_sticky), 64'(0));
  endtask

  task automatic random_traffic(input int n);
    int ri, rj;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        pulse_dim();
      end else begin
        ri = int'($urandom_range(0, 8)) - 2;
        rj = int'($urandom_range(0, 16)) - 2;
        if ($urandom_range(0, 24) == 0) ri = int'(32'h8000_0000);
        if ($urandom_range(0, 24) == 0) rj = int'(32'h7fff_ffff);
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ri, rj, $urandom);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    #1;
    check_reset_outputs("init");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Command held during the initial clear; accepted once clearing ends.
    for (int k = 0; k < 200; k++) begin
      drive(1'b1, 1'b0, MI, MJ, '0);
      if (busy_left == 0) break;
    end
    idle(3);

    for (int i = 0; i <= MI; i++)
      for (int j = 0; j <= MJ; j++)
        drive(1'b1, 1'b1, i, j, DW'(i + j));
    for (int i = 0; i <= MI; i++)
      for (int j = 0; j <= MJ; j++)
        drive(1'b1, 1'b0, i, j, '0);
    drive(1'b1, 1'b0, 2, 7, '0);
    idle(2);

    drive(1'b1, 1'b1, 1, 3, 77);
    drive(1'b1, 1'b0, 1, 3, '0);
    idle(2);

    drive(1'b1, 1'b0, 5, 0, '0);
    drive(1'b1, 1'b1, -1, 13, 5);
    drive(1'b1, 1'b0, 0, 12, '0);
    idle(3);

    drive(1'b1, 1'b0, 9, 0, '0);
    drive(1'b1, 1'b0, 1, 1, '0);
    drive(1'b1, 1'b0, 2, 2, '0);
    pulse_dim();
    wait_ready();
    drive(1'b1, 1'b0, 2, 7, '0);
    idle(3);

    random_traffic(400);
    wait_ready();

    drive(1'b1, 1'b1, 0, 0, 32'h0000_abcd);
    drive(1'b1, 1'b0, 0, 0, '0);
    idle(3);
    pulse_dim();
    idle(30);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midclr");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_ready();
    drive(1'b1, 1'b0, 0, 0, '0);
    drive(1'b1, 1'b1, 3, 11, 32'hdead_beef);
    drive(1'b1, 1'b0, 3, 11, '0);
    drive(1'b1, 1'b0, 0, 13, '0);
    random_traffic(200);
    idle(5);

    check("drain", 64'(q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
